// File: rtl/axilite_pkg.sv
// Shared response codes, scheduler states and grant encoding
// for the AXI-lite transaction scheduler.
package axilite_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      WR_REQ,
      RD_RESP,
      WR_RESP
   } sched_state_e;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_e;
endpackage

// File: rtl/axilite_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant register only
// advances when a grant is actually taken (i_en).
module axilite_rr_arb2
   import axilite_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_req_rd,
   input  logic   i_req_wr,
   input  logic   i_en,
   output logic   o_valid,
   output grant_e o_gnt
);
   grant_e r_last;
   logic   w_both;

   assign w_both  = i_req_rd & i_req_wr;
   assign o_valid = i_req_rd | i_req_wr;

   always_comb begin
      o_gnt = GRANT_READ;
      if (w_both) begin
         o_gnt = (r_last == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
      end else if (i_req_wr) begin
         o_gnt = GRANT_WRITE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= GRANT_WRITE;
      end else if (i_en && o_valid) begin
         r_last <= o_gnt;
      end
   end
endmodule

// File: rtl/axilite_txn_sched.sv
// AXI-lite slave scheduler: arbitrates held AR/AW+W requests onto one
// register port with ack timeout, and returns R/B responses.
module axilite_txn_sched
   import axilite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'h0000_1000,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   raddr_held,
   input  logic                    raddr_ready,
   output logic                    raddr_deassert,
   input  logic [ADDR_WIDTH-1:0]   waddr_held,
   input  logic                    waddr_ready,
   output logic                    waddr_deassert,
   input  logic [DATA_WIDTH-1:0]   wdata_held,
   input  logic [DATA_WIDTH/8-1:0] wstrb_held,
   input  logic                    wdata_ready,
   output logic                    wdata_deassert,
   output logic                    reg_req,
   output logic                    reg_we,
   output logic [ADDR_WIDTH-1:0]   reg_addr,
   output logic [DATA_WIDTH-1:0]   reg_wdata,
   output logic [DATA_WIDTH/8-1:0] reg_wstrb,
   input  logic                    reg_ack,
   input  logic [DATA_WIDTH-1:0]   reg_rdata,
   input  logic                    reg_err,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   sched_state_e r_state, w_state_n;
   logic [CW-1:0]         r_cnt, w_cnt_n;
   logic                  r_req, w_req_n;
   logic                  r_we, w_we_n;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
   logic [SW-1:0]         r_wstrb, w_wstrb_n;
   logic                  r_rdeas, w_rdeas_n;
   logic                  r_wdeas, w_wdeas_n;
   logic                  r_rvalid, w_rvalid_n;
   logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
   logic [1:0]            r_rresp, w_rresp_n;
   logic                  r_bvalid, w_bvalid_n;
   logic [1:0]            r_bresp, w_bresp_n;

   logic                  w_gvalid;
   grant_e                w_gnt;
   logic [ADDR_WIDTH-1:0] w_gaddr;
   logic                  w_oor;
   logic                  w_timeout;
   logic [1:0]            w_ack_resp;

   axilite_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst),
      .i_req_rd (raddr_ready),
      .i_req_wr (waddr_ready & wdata_ready),
      .i_en     (r_state == IDLE),
      .o_valid  (w_gvalid),
      .o_gnt    (w_gnt)
   );

   assign w_gaddr    = (w_gnt == GRANT_READ) ? raddr_held : waddr_held;
   assign w_oor      = (w_gaddr >= ADDR_LIMIT);
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
   assign w_ack_resp = reg_err ? RESP_SLVERR : RESP_OKAY;

   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_req_n    = r_req;
      w_we_n     = r_we;
      w_addr_n   = r_addr;
      w_wdata_n  = r_wdata;
      w_wstrb_n  = r_wstrb;
      w_rdeas_n  = 1'b0;
      w_wdeas_n  = 1'b0;
      w_rvalid_n = r_rvalid;
      w_rdata_n  = r_rdata;
      w_rresp_n  = r_rresp;
      w_bvalid_n = r_bvalid;
      w_bresp_n  = r_bresp;
      unique case (r_state)
         IDLE: begin
            if (w_gvalid) begin
               w_addr_n = w_gaddr;
               w_cnt_n  = '0;
               if (w_gnt == GRANT_READ) begin
                  w_we_n    = 1'b0;
                  w_rdeas_n = 1'b1;
                  if (w_oor) begin
                     w_state_n  = RD_RESP;
                     w_rvalid_n = 1'b1;
                     w_rdata_n  = '0;
                     w_rresp_n  = RESP_DECERR;
                  end else begin
                     w_state_n = RD_REQ;
                     w_req_n   = 1'b1;
                  end
               end else begin
                  w_we_n    = 1'b1;
                  w_wdata_n = wdata_held;
                  w_wstrb_n = wstrb_held;
                  w_wdeas_n = 1'b1;
                  if (w_oor) begin
                     w_state_n  = WR_RESP;
                     w_bvalid_n = 1'b1;
                     w_bresp_n  = RESP_DECERR;
                  end else begin
                     w_state_n = WR_REQ;
                     w_req_n   = 1'b1;
                  end
               end
            end
         end
         RD_REQ, WR_REQ: begin
            // ack outranks a timeout landing on the same edge
            if (reg_ack || w_timeout) begin
               w_req_n = 1'b0;
               w_cnt_n = '0;
               if (r_state == RD_REQ) begin
                  w_state_n  = RD_RESP;
                  w_rvalid_n = 1'b1;
                  w_rdata_n  = reg_ack ? reg_rdata : '0;
                  w_rresp_n  = reg_ack ? w_ack_resp : RESP_SLVERR;
               end else begin
                  w_state_n  = WR_RESP;
                  w_bvalid_n = 1'b1;
                  w_bresp_n  = reg_ack ? w_ack_resp : RESP_SLVERR;
               end
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         RD_RESP: begin
            if (rready) begin
               w_rvalid_n = 1'b0;
               w_state_n  = IDLE;
            end
         end
         WR_RESP: begin
            if (bready) begin
               w_bvalid_n = 1'b0;
               w_state_n  = IDLE;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_rdeas  <= 1'b0;
         r_wdeas  <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= '0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_req    <= w_req_n;
         r_we     <= w_we_n;
         r_addr   <= w_addr_n;
         r_wdata  <= w_wdata_n;
         r_wstrb  <= w_wstrb_n;
         r_rdeas  <= w_rdeas_n;
         r_wdeas  <= w_wdeas_n;
         r_rvalid <= w_rvalid_n;
         r_rdata  <= w_rdata_n;
         r_rresp  <= w_rresp_n;
         r_bvalid <= w_bvalid_n;
         r_bresp  <= w_bresp_n;
      end
   end

   assign raddr_deassert = r_rdeas;
   assign waddr_deassert = r_wdeas;
   assign wdata_deassert = r_wdeas;
   assign reg_req        = r_req;
   assign reg_we         = r_we;
   assign reg_addr       = r_addr;
   assign reg_wdata      = r_wdata;
   assign reg_wstrb      = r_wstrb;
   assign rvalid         = r_rvalid;
   assign rdata          = r_rdata;
   assign rresp          = r_rresp;
   assign bvalid         = r_bvalid;
   assign bresp          = r_bresp;
endmodule

// File: tb/tb_axilite_txn_sched.sv
// Directed bench for axilite_txn_sched: inputs driven and outputs
// sampled on the falling edge, expectations hand-derived per scenario.
module tb_axilite_txn_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] raddr_held = '0;
   logic        raddr_ready = 1'b0;
   logic        raddr_deassert;
   logic [31:0] waddr_held = '0;
   logic        waddr_ready = 1'b0;
   logic        waddr_deassert;
   logic [31:0] wdata_held = '0;
   logic [3:0]  wstrb_held = '0;
   logic        wdata_ready = 1'b0;
   logic        wdata_deassert;
   logic        reg_req;
   logic        reg_we;
   logic [31:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic        reg_ack = 1'b0;
   logic [31:0] reg_rdata = '0;
   logic        reg_err = 1'b0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [1:0]  bresp;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axilite_txn_sched dut (
      .clk            (clk),
      .rst            (rst),
      .raddr_held     (raddr_held),
      .raddr_ready    (raddr_ready),
      .raddr_deassert (raddr_deassert),
      .waddr_held     (waddr_held),
      .waddr_ready    (waddr_ready),
      .waddr_deassert (waddr_deassert),
      .wdata_held     (wdata_held),
      .wstrb_held     (wstrb_held),
      .wdata_ready    (wdata_ready),
      .wdata_deassert (wdata_deassert),
      .reg_req        (reg_req),
      .reg_we         (reg_we),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_wstrb      (reg_wstrb),
      .reg_ack        (reg_ack),
      .reg_rdata      (reg_rdata),
      .reg_err        (reg_err),
      .rvalid         (rvalid),
      .rready         (rready),
      .rdata          (rdata),
      .rresp          (rresp),
      .bvalid         (bvalid),
      .bready         (bready),
      .bresp          (bresp)
   );

   task automatic test_reset();
      logic [6:0] ctl;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      ctl = {reg_req, reg_we, rvalid, bvalid,
             raddr_deassert, waddr_deassert, wdata_deassert};
      checks++;
      if (ctl !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=0000000", ctl);
      end
      checks++;
      if ({reg_addr, reg_wdata, rdata} !== 96'b0 ||
          {reg_wstrb, rresp, bresp} !== 8'b0) begin
         failures++;
         $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0",
                  reg_addr, reg_wdata, rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({reg_req, rvalid, bvalid} !== 3'b0) begin
         failures++;
         $display("FAIL reset_release got=%b exp=000",
                  {reg_req, rvalid, bvalid});
      end
   endtask

   task automatic test_read_ok();
      @(negedge clk);
      raddr_held = 32'h10; raddr_ready = 1'b1;
      reg_rdata = 32'hDEADBEEF; reg_ack = 1'b1; reg_err = 1'b0;
      @(negedge clk);
      checks++;
      if ({raddr_deassert, reg_req, reg_we, rvalid} !== 4'b1100 ||
          reg_addr !== 32'h10) begin
         failures++;
         $display("FAIL rd_grant got=%b addr=%h exp=1100 addr=10",
                  {raddr_deassert, reg_req, reg_we, rvalid}, reg_addr);
      end
      raddr_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({rvalid, raddr_deassert, reg_req} !== 3'b100 ||
          rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
         failures++;
         $display("FAIL rd_resp got=%b rdata=%h rresp=%b exp=100 deadbeef 00",
                  {rvalid, raddr_deassert, reg_req}, rdata, rresp);
      end
      reg_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rd_hold rvalid=%b rdata=%h exp=1 deadbeef",
                  rvalid, rdata);
      end
      rready = 1'b1;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rd_clear rvalid=%b exp=0", rvalid);
      end
      rready = 1'b0;
   endtask

   task automatic test_write_ack3();
      @(negedge clk);
      waddr_held = 32'h20; waddr_ready = 1'b1;
      wdata_held = 32'h12345678; wstrb_held = 4'b0011;
      wdata_ready = 1'b1; reg_ack = 1'b0; reg_err = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (reg_req !== 1'b1 || reg_we !== 1'b1 ||
             reg_wstrb !== 4'b0011 || reg_wdata !== 32'h12345678 ||
             reg_addr !== 32'h20 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_req%0d req=%b we=%b strb=%b wdata=%h bvalid=%b",
                     k, reg_req, reg_we, reg_wstrb, reg_wdata, bvalid);
         end
         if (k == 1) begin
            checks++;
            if ({waddr_deassert, wdata_deassert} !== 2'b11) begin
               failures++;
               $display("FAIL wr_deassert got=%b exp=11",
                        {waddr_deassert, wdata_deassert});
            end
            waddr_ready = 1'b0; wdata_ready = 1'b0;
         end
         if (k == 3) reg_ack = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({bvalid, reg_req, rvalid, waddr_deassert} !== 4'b1000 ||
          bresp !== 2'b00) begin
         failures++;
         $display("FAIL wr_resp got=%b bresp=%b exp=1000 00",
                  {bvalid, reg_req, rvalid, waddr_deassert}, bresp);
      end
      reg_ack = 1'b0; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         failures++;
         $display("FAIL wr_clear bvalid=%b exp=0", bvalid);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int pair_bad = 0;
      int both_bad = 0;
      logic [5:0] seq = '0;
      bit rd_rel = 0;
      bit wr_rel = 0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      raddr_held = 32'h10; waddr_held = 32'h20;
      wdata_held = 32'hA5A5A5A5; wstrb_held = 4'hF;
      reg_rdata = 32'h11; reg_ack = 1'b1; reg_err = 1'b0;
      rready = 1'b1; bready = 1'b1;
      raddr_ready = 1'b1; waddr_ready = 1'b1; wdata_ready = 1'b1;
      for (int c = 0; c < 200 && n < 6; c++) begin
         @(negedge clk);
         if (rd_rel) raddr_ready = 1'b1;
         if (wr_rel) begin
            waddr_ready = 1'b1; wdata_ready = 1'b1;
         end
         rd_rel = 0; wr_rel = 0;
         if (raddr_deassert) begin
            raddr_ready = 1'b0; rd_rel = 1;
            if (n < 6) seq[n] = 1'b0;
            n++;
         end
         if (waddr_deassert) begin
            waddr_ready = 1'b0; wdata_ready = 1'b0; wr_rel = 1;
            if (n < 6) seq[n] = 1'b1;
            n++;
         end
         if (waddr_deassert !== wdata_deassert) pair_bad++;
         if (rvalid && bvalid) both_bad++;
      end
      raddr_ready = 1'b0; waddr_ready = 1'b0; wdata_ready = 1'b0;
      checks++;
      if (n !== 6) begin
         failures++;
         $display("FAIL rr_count grants=%0d exp=6", n);
      end
      checks++;
      if (seq !== 6'b101010) begin
         failures++;
         $display("FAIL rr_order got=%b exp=101010 (bit0 first, 1=W)", seq);
      end
      checks++;
      if (pair_bad !== 0 || both_bad !== 0) begin
         failures++;
         $display("FAIL rr_excl pair_bad=%0d both_bad=%0d exp=0 0",
                  pair_bad, both_bad);
      end
      repeat (8) @(negedge clk);
      checks++;
      if ({rvalid, bvalid, reg_req} !== 3'b000) begin
         failures++;
         $display("FAIL rr_drain got=%b exp=000", {rvalid, bvalid, reg_req});
      end
      rready = 1'b0; bready = 1'b0; reg_ack = 1'b0;
   endtask

   task automatic test_decerr();
      @(negedge clk);
      raddr_held = 32'h2000; raddr_ready = 1'b1;
      reg_rdata = 32'hDEADBEEF; reg_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({rvalid, reg_req, raddr_deassert} !== 3'b101 ||
          rresp !== 2'b11 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL decerr got=%b rresp=%b rdata=%h exp=101 11 0",
                  {rvalid, reg_req, raddr_deassert}, rresp, rdata);
      end
      checks++;
      if (reg_wdata !== 32'hA5A5A5A5 || reg_wstrb !== 4'hF) begin
         failures++;
         $display("FAIL rd_keeps_w wdata=%h strb=%h exp=a5a5a5a5 f",
                  reg_wdata, reg_wstrb);
      end
      raddr_ready = 1'b0; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checks++;
      if ({rvalid, reg_req} !== 2'b00) begin
         failures++;
         $display("FAIL decerr_done got=%b exp=00", {rvalid, reg_req});
      end
   endtask

   task automatic test_timeout();
      int reqc = 0;
      bit got = 0;
      @(negedge clk);
      waddr_held = 32'h40; waddr_ready = 1'b1;
      wdata_held = 32'h0BADF00D; wstrb_held = 4'h1;
      wdata_ready = 1'b1; reg_ack = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (waddr_deassert) begin
            waddr_ready = 1'b0; wdata_ready = 1'b0;
         end
         if (bvalid) begin
            got = 1;
            break;
         end
         if (reg_req) reqc++;
      end
      checks++;
      if (got !== 1'b1 || reqc !== 16) begin
         failures++;
         $display("FAIL timeout_len got_b=%0d req_cycles=%0d exp=1 16",
                  got, reqc);
      end
      checks++;
      if (bresp !== 2'b10 || reg_req !== 1'b0) begin
         failures++;
         $display("FAIL timeout_resp bresp=%b req=%b exp=10 0",
                  bresp, reg_req);
      end
      waddr_ready = 1'b0; wdata_ready = 1'b0;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic test_slverr();
      @(negedge clk);
      waddr_held = 32'h44; waddr_ready = 1'b1;
      wdata_held = 32'h1; wdata_ready = 1'b1;
      reg_ack = 1'b1; reg_err = 1'b1;
      @(negedge clk);
      waddr_ready = 1'b0; wdata_ready = 1'b0;
      checks++;
      if (reg_req !== 1'b1) begin
         failures++;
         $display("FAIL slverr_req req=%b exp=1", reg_req);
      end
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b10) begin
         failures++;
         $display("FAIL slverr_resp bvalid=%b bresp=%b exp=1 10",
                  bvalid, bresp);
      end
      reg_ack = 1'b0; reg_err = 1'b0; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         failures++;
         $display("FAIL slverr_clear bvalid=%b exp=0", bvalid);
      end
   endtask

   task automatic test_aw_only();
      int bad = 0;
      @(negedge clk);
      waddr_held = 32'h50; waddr_ready = 1'b1; wdata_ready = 1'b0;
      reg_ack = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (waddr_deassert || wdata_deassert || reg_req || bvalid) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL aw_only_idle busy_cycles=%0d exp=0", bad);
      end
      wdata_held = 32'h77; wstrb_held = 4'hC; wdata_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({waddr_deassert, wdata_deassert, reg_req} !== 3'b111 ||
          reg_wdata !== 32'h77 || reg_addr !== 32'h50) begin
         failures++;
         $display("FAIL aw_then_w got=%b wdata=%h addr=%h exp=111 77 50",
                  {waddr_deassert, wdata_deassert, reg_req},
                  reg_wdata, reg_addr);
      end
      waddr_ready = 1'b0; wdata_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         failures++;
         $display("FAIL aw_then_w_resp bvalid=%b bresp=%b exp=1 00",
                  bvalid, bresp);
      end
      reg_ack = 1'b0; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      raddr_held = 32'h30; raddr_ready = 1'b1; reg_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({reg_req, raddr_deassert} !== 2'b11) begin
         failures++;
         $display("FAIL mid_pre got=%b exp=11", {reg_req, raddr_deassert});
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({reg_req, reg_we, raddr_deassert, rvalid, bvalid} !== 5'b0 ||
          reg_addr !== 32'h0 || reg_wdata !== 32'h0) begin
         failures++;
         $display("FAIL mid_reset got=%b addr=%h wdata=%h exp=00000 0 0",
                  {reg_req, reg_we, raddr_deassert, rvalid, bvalid},
                  reg_addr, reg_wdata);
      end
      raddr_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({reg_req, raddr_deassert, rvalid} !== 3'b000) begin
         failures++;
         $display("FAIL mid_idle got=%b exp=000",
                  {reg_req, raddr_deassert, rvalid});
      end
      raddr_held = 32'h14; raddr_ready = 1'b1;
      reg_rdata = 32'hCAFE0001; reg_ack = 1'b1;
      @(negedge clk);
      raddr_ready = 1'b0;
      checks++;
      if ({reg_req, raddr_deassert} !== 2'b11 || reg_addr !== 32'h14) begin
         failures++;
         $display("FAIL mid_regrant got=%b addr=%h exp=11 14",
                  {reg_req, raddr_deassert}, reg_addr);
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || rresp !== 2'b00) begin
         failures++;
         $display("FAIL mid_read rvalid=%b rdata=%h rresp=%b exp=1 cafe0001 00",
                  rvalid, rdata, rresp);
      end
      reg_ack = 1'b0; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read_ok();
      test_write_ack3();
      test_back_to_back();
      test_decerr();
      test_timeout();
      test_slverr();
      test_aw_only();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axilite_txn_sched.md
Name: axilite_txn_sched

Overview:
- Sequences AXI-lite slave transactions between the channel holders and a single internal register port.
- Inputs come from three holders: read-address (AR), write-address (AW) and write-data (W). Each holder presents a held value plus a ready flag, and frees its value when it sees a one-cycle deassert pulse.
- Arbitrates reads against writes round-robin, range-checks the address, and drives the register port with an ack timeout.
- Generates the R and B response channels back to the AXI master.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- ADDR_LIMIT, 32'h0000_1000, first decoded-out byte address; any address >= ADDR_LIMIT gets DECERR.
- TIMEOUT_CYCLES, 16, maximum cycles reg_req may stay high without reg_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- raddr_held  in  ADDR_WIDTH  held AR address
- raddr_ready  in  1  AR holder has an address
- raddr_deassert  out  1  one-cycle pulse releasing AR holder
- waddr_held  in  ADDR_WIDTH  held AW address
- waddr_ready  in  1  AW holder has an address
- waddr_deassert  out  1  release pulse, AW
- wdata_held  in  DATA_WIDTH  held W data
- wstrb_held  in  DATA_WIDTH/8  held W strobes
- wdata_ready  in  1  W holder has data
- wdata_deassert  out  1  release pulse, W
- reg_req  out  1  register access request
- reg_we  out  1  1 = write
- reg_addr  out  ADDR_WIDTH  access address
- reg_wdata  out  DATA_WIDTH  write data
- reg_wstrb  out  DATA_WIDTH/8  write strobes
- reg_ack  in  1  access complete (same-cycle ack allowed)
- reg_rdata  in  DATA_WIDTH  read data, valid with reg_ack
- reg_err  in  1  slave error, valid with reg_ack
- rvalid  out  1  R channel valid
- rready  in  1  R channel ready
- rdata  out  DATA_WIDTH  R channel data
- rresp  out  2  R channel response
- bvalid  out  1  B channel valid
- bready  in  1  B channel ready
- bresp  out  2  B channel response

Behaviour:
- All outputs are registered.
- Reset (rst low) takes effect immediately:
  - state = IDLE, last_grant = WRITE (so the first tie goes to read).
  - All outputs 0, timeout counter 0.
  - Any in-flight transaction is abandoned with no response.
- Pending conditions:
  - rd_pend = raddr_ready.
  - wr_pend = waddr_ready & wdata_ready. An AW without its W, or a W without its AW, never triggers a grant.
- IDLE:
  - Only rd_pend: grant read. Only wr_pend: grant write. Both: grant the side opposite last_grant.
  - On grant: latch address (and data/strobes for a write) into reg_addr, reg_wdata and reg_wstrb; set reg_we; update last_grant.
  - Next cycle, pulse the granted holder's deassert for exactly 1 cycle. A write pulses both waddr_deassert and wdata_deassert.
  - Granted address < ADDR_LIMIT: go to RD_REQ or WR_REQ.
  - Granted address >= ADDR_LIMIT: skip the register port and go straight to RD_RESP or WR_RESP with resp = DECERR (2'b11) and rdata = 0.
- RD_REQ / WR_REQ:
  - reg_req = 1 from the first cycle of the state; the counter increments each cycle.
  - reg_ack sampled high: drop reg_req and go to RESP. rresp/bresp = reg_err ? SLVERR (2'b10) : OKAY (2'b00). On a read, rdata = reg_rdata.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop reg_req, resp = SLVERR, rdata = 0.
  - If ack and timeout occur in the same cycle, ack wins.
- RD_RESP / WR_RESP:
  - rvalid or bvalid is held, with payload stable, until rready or bready is sampled high; then clear it and return to IDLE.
  - No new grant is made in the same cycle that the response completes.
- Only one transaction is outstanding at any time; R and B are never valid simultaneously.
- Latency:
  - OKAY read with same-cycle ack: rvalid rises 2 cycles after raddr_ready is sampled.
  - DECERR: response valid 1 cycle after grant.
- Holder safety: a deassert pulse always precedes the controller's return to IDLE by at least 1 cycle, so a stale ready flag is never re-granted.
- Reads ignore wdata and wstrb. reg_wdata and reg_wstrb keep their last values during reads.

Decomposition:
- Shared package axilite_pkg holds:
  - RESP_OKAY, RESP_SLVERR, RESP_DECERR constants.
  - The scheduler state enum {IDLE, RD_REQ, WR_REQ, RD_RESP, WR_RESP}.
  - The grant encoding {GRANT_READ, GRANT_WRITE}.
- One sub-module: axilite_rr_arb2, a 2-requester round-robin arbiter with last-grant register and grant-enable input, reused later for multi-master sharing.

Test Plan:
- Read 0x10 with reg_rdata=0xDEADBEEF and ack in the same cycle -> single raddr_deassert pulse; rvalid 2 cycles later; rdata=0xDEADBEEF, rresp=00; rvalid held until rready.
- Write 0x20, data 0x12345678, wstrb 4'b0011, ack after 3 cycles -> reg_req high for 3 cycles with reg_we=1, reg_wstrb=0011; waddr_deassert and wdata_deassert pulse together; bresp=00.
- Read and write both pending from reset, repeatedly -> grants alternate R, W, R, W starting with read; no holder ever waits for more than one other transaction.
- Read 0x2000 (>= ADDR_LIMIT) -> reg_req never asserted; rresp=11, rdata=0.
- Write with reg_ack never asserted -> reg_req drops after 16 cycles; bresp=10. Same run with reg_err=1 on ack -> bresp=10.
- AW only, no W for 20 cycles, then W -> no grant until W arrives. Drive rst low mid-RD_REQ -> all outputs 0 immediately; IDLE after release.
